// File: rtl/uart_prog_loader.sv
// Parses framed program-load packets from a UART byte stream and writes the payload
// as little-endian 32-bit words to memory over a req/gnt port.
module uart_prog_loader #(
  parameter int unsigned       ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter logic [7:0]        SYNC_BYTE    = 8'hA5,
  parameter int unsigned       TIMEOUT_CLKS = 32'd1000000
) (
  input  logic              i_Clock,
  input  logic              rst_ni,
  input  logic              i_Rx_DV,
  input  logic [7:0]        i_Rx_Byte,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic              i_mem_gnt,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [1:0]        o_err_code,
  output logic [15:0]       o_word_cnt
);

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StData,
    StCsum,
    StFinish
  } state_e;

  localparam logic [31:0] TmoLast = 32'(TIMEOUT_CLKS - 1);

  state_e              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [7:0]          csum_q, csum_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [23:0]         word_q, word_d;
  logic [15:0]         word_idx_q, word_idx_d;
  logic                req_q, req_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [1:0]          code_q, code_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [31:0]         tmo_q, tmo_d;
  logic                csum_ok_q, csum_ok_d;

  logic       counting;
  logic       abort;
  logic [1:0] abort_code;

  assign counting = (state_q == StLenLo) || (state_q == StLenHi) ||
                    (state_q == StData)  || (state_q == StCsum);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    csum_d     = csum_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    word_idx_d = word_idx_q;
    req_d      = req_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    code_d     = code_q;
    cnt_d      = cnt_q;
    csum_ok_d  = csum_ok_q;
    abort      = 1'b0;
    abort_code = 2'd0;

    if (req_q && i_mem_gnt) begin
      req_d = 1'b0;
      cnt_d = cnt_q + 16'd1;
    end

    if (state_q == StIdle || i_Rx_DV) begin
      tmo_d = '0;
    end else if (counting) begin
      tmo_d = tmo_q + 32'd1;
    end else begin
      tmo_d = tmo_q;
    end

    // A byte in the same cycle always beats the timeout.
    if (counting && !i_Rx_DV && (tmo_q == TmoLast)) begin
      abort      = 1'b1;
      abort_code = 2'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
          state_d    = StLenLo;
          csum_d     = '0;
          cnt_d      = '0;
          byte_idx_d = '0;
          word_idx_d = '0;
        end
      end
      StLenLo: begin
        if (i_Rx_DV) begin
          len_d[7:0] = i_Rx_Byte;
          csum_d     = csum_q ^ i_Rx_Byte;
          state_d    = StLenHi;
        end
      end
      StLenHi: begin
        if (i_Rx_DV) begin
          len_d[15:8] = i_Rx_Byte;
          csum_d      = csum_q ^ i_Rx_Byte;
          state_d     = ({i_Rx_Byte, len_q[7:0]} == 16'd0) ? StCsum : StData;
        end
      end
      StData: begin
        if (i_Rx_DV) begin
          if ((byte_idx_q == 2'd3) && req_q && !i_mem_gnt) begin
            abort      = 1'b1;
            abort_code = 2'd2;
          end else begin
            csum_d     = csum_q ^ i_Rx_Byte;
            byte_idx_d = byte_idx_q + 2'd1;
            case (byte_idx_q)
              2'd0: word_d[7:0]   = i_Rx_Byte;
              2'd1: word_d[15:8]  = i_Rx_Byte;
              2'd2: word_d[23:16] = i_Rx_Byte;
              default: begin
                req_d      = 1'b1;
                wdata_d    = {i_Rx_Byte, word_q};
                addr_d     = BASE_ADDR + ADDR_W'({word_idx_q, 2'b00});
                word_idx_d = word_idx_q + 16'd1;
                if ((word_idx_q + 16'd1) == len_q) begin
                  state_d = StCsum;
                end
              end
            endcase
          end
        end
      end
      StCsum: begin
        if (i_Rx_DV) begin
          csum_ok_d = (i_Rx_Byte == csum_q);
          state_d   = StFinish;
        end
      end
      StFinish: begin
        if (!req_q) begin
          state_d = StIdle;
          if (csum_ok_q) begin
            done_d = 1'b1;
          end else begin
            err_d  = 1'b1;
            code_d = 2'd3;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort abandons any pending write and drops the byte seen this cycle.
    if (abort) begin
      req_d   = 1'b0;
      err_d   = 1'b1;
      code_d  = abort_code;
      state_d = StIdle;
      tmo_d   = '0;
    end
  end

  always_ff @(posedge i_Clock or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      len_q      <= '0;
      csum_q     <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      word_idx_q <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      csum_ok_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      csum_q     <= csum_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      word_idx_q <= word_idx_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
      code_q     <= code_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      csum_ok_q  <= csum_ok_d;
    end
  end

  assign o_mem_req   = req_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_busy      = (state_q != StIdle);
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_err_code  = code_q;
  assign o_word_cnt  = cnt_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: good frames, checksum error, overflow, backpressure,
// timeout and mid-frame reset.
module tb_uart_prog_loader;

  localparam logic [31:0] Base = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        gnt = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [15:0] word_cnt;

  int          n_checks = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0]  seq[$];

  always #5 clk = ~clk;

  uart_prog_loader #(
    .ADDR_W      (32),
    .BASE_ADDR   (Base),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CLKS(50)
  ) dut (
    .i_Clock    (clk),
    .rst_ni     (rst_n),
    .i_Rx_DV    (rx_dv),
    .i_Rx_Byte  (rx_byte),
    .o_mem_req  (mem_req),
    .o_mem_addr (mem_addr),
    .o_mem_wdata(mem_wdata),
    .i_mem_gnt  (gnt),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err),
    .o_err_code (err_code),
    .o_word_cnt (word_cnt)
  );

  // Inputs change at negedge; sampling 1ns later sees what the next posedge will use.
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (mem_req && gnt) begin
        wr_addr.push_back(mem_addr);
        wr_data.push_back(mem_wdata);
      end
      if (done) done_cnt++;
      if (err) err_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv   = 1'b0;
  endtask

  task automatic send_seq();
    foreach (seq[i]) begin
      send_byte(seq[i]);
      idle(2);
    end
  endtask

  task automatic clear_mon();
    done_cnt = 0;
    err_cnt  = 0;
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic wait_end(input string tag, input int max);
    for (int k = 0; k < max; k++) begin
      if (done_cnt + err_cnt > 0) break;
      @(negedge clk);
      #2;
    end
    check_eq(tag, 64'(done_cnt + err_cnt > 0), 64'd1);
    idle(3);
  endtask

  task automatic check_write(input string tag, input int idx, input logic [31:0] a,
                             input logic [31:0] d);
    if (wr_addr.size() > idx) begin
      check_eq({tag, "_addr"}, 64'(wr_addr[idx]), 64'(a));
      check_eq({tag, "_data"}, 64'(wr_data[idx]), 64'(d));
    end else begin
      check_eq({tag, "_present"}, 64'(wr_addr.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    int cyc;

    // Reset state
    idle(3);
    check_eq("rst_req", 64'(mem_req), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    check_eq("rst_code", 64'(err_code), 64'd0);
    check_eq("rst_cnt", 64'(word_cnt), 64'd0);
    rst_n = 1'b1;
    idle(2);

    // 1) single word, checksum 0x09
    gnt = 1'b1;
    clear_mon();
    seq = {8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
    send_seq();
    wait_end("t1_end", 50);
    check_eq("t1_done", 64'(done_cnt), 64'd1);
    check_eq("t1_err", 64'(err_cnt), 64'd0);
    check_eq("t1_nwr", 64'(wr_addr.size()), 64'd1);
    check_write("t1_w0", 0, Base, 32'h1234_5678);
    check_eq("t1_cnt", 64'(word_cnt), 64'd1);
    check_eq("t1_busy", 64'(busy), 64'd0);

    // 2) three words, checksum 0x65
    clear_mon();
    seq = {8'hA5, 8'h03, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA,
           8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h65};
    send_seq();
    wait_end("t2_end", 50);
    check_eq("t2_done", 64'(done_cnt), 64'd1);
    check_eq("t2_nwr", 64'(wr_addr.size()), 64'd3);
    check_write("t2_w0", 0, Base, 32'h1122_3344);
    check_write("t2_w1", 1, Base + 32'd4, 32'hAABB_CCDD);
    check_write("t2_w2", 2, Base + 32'd8, 32'hDEAD_BEEF);
    check_eq("t2_cnt", 64'(word_cnt), 64'd3);

    // 3) empty frames: good and bad checksum
    clear_mon();
    seq = {8'hA5, 8'h00, 8'h00, 8'h00};
    send_seq();
    wait_end("t3a_end", 50);
    check_eq("t3a_done", 64'(done_cnt), 64'd1);
    check_eq("t3a_nwr", 64'(wr_addr.size()), 64'd0);
    check_eq("t3a_cnt", 64'(word_cnt), 64'd0);
    clear_mon();
    seq = {8'hA5, 8'h00, 8'h00, 8'hFF};
    send_seq();
    wait_end("t3b_end", 50);
    check_eq("t3b_err", 64'(err_cnt), 64'd1);
    check_eq("t3b_done", 64'(done_cnt), 64'd0);
    check_eq("t3b_code", 64'(err_code), 64'd3);

    // 4a) grant withheld across two completed words -> overflow
    gnt = 1'b0;
    clear_mon();
    seq = {8'hA5, 8'h03, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
    send_seq();
    wait_end("t4a_end", 50);
    check_eq("t4a_err", 64'(err_cnt), 64'd1);
    check_eq("t4a_code", 64'(err_code), 64'd2);
    check_eq("t4a_req", 64'(mem_req), 64'd0);
    check_eq("t4a_busy", 64'(busy), 64'd0);
    check_eq("t4a_nwr", 64'(wr_addr.size()), 64'd0);

    // 4b) grant withheld past the checksum, then given
    clear_mon();
    seq = {8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
    send_seq();
    idle(10);
    check_eq("t4b_nodone", 64'(done_cnt + err_cnt), 64'd0);
    check_eq("t4b_req_held", 64'(mem_req), 64'd1);
    check_eq("t4b_busy", 64'(busy), 64'd1);
    gnt = 1'b1;
    wait_end("t4b_end", 50);
    check_eq("t4b_done", 64'(done_cnt), 64'd1);
    check_write("t4b_w0", 0, Base, 32'h1234_5678);
    check_eq("t4b_cnt", 64'(word_cnt), 64'd1);

    // 5) stall after LEN_HI -> timeout 50 clocks after the last byte
    clear_mon();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    cyc = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      #1;
      if (err) begin
        cyc = k;
        break;
      end
    end
    check_eq("t5_latency", 64'(cyc), 64'd50);
    idle(3);
    check_eq("t5_code", 64'(err_code), 64'd1);
    check_eq("t5_err", 64'(err_cnt), 64'd1);
    check_eq("t5_busy", 64'(busy), 64'd0);
    clear_mon();
    seq = {8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
    send_seq();
    wait_end("t5_reload_end", 50);
    check_eq("t5_reload_done", 64'(done_cnt), 64'd1);
    check_write("t5_w0", 0, Base, 32'h1234_5678);
    check_eq("t5_code_held", 64'(err_code), 64'd1);

    // 6) idle garbage ignored; reset mid-payload; fresh frame
    clear_mon();
    seq = {8'h00, 8'hFF, 8'h12, 8'h5A};
    send_seq();
    check_eq("t6_garbage_busy", 64'(busy), 64'd0);
    check_eq("t6_garbage_evt", 64'(done_cnt + err_cnt), 64'd0);
    seq = {8'hA5, 8'h01, 8'h00, 8'h78, 8'h56};
    send_seq();
    check_eq("t6_busy_pre", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_busy", 64'(busy), 64'd0);
    check_eq("t6_rst_code", 64'(err_code), 64'd0);
    check_eq("t6_rst_req", 64'(mem_req), 64'd0);
    check_eq("t6_rst_cnt", 64'(word_cnt), 64'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    clear_mon();
    seq = {8'hA5, 8'h03, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA,
           8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h65};
    send_seq();
    wait_end("t6_end", 50);
    check_eq("t6_done", 64'(done_cnt), 64'd1);
    check_write("t6_w0", 0, Base, 32'h1122_3344);
    check_write("t6_w2", 2, Base + 32'd8, 32'hDEAD_BEEF);
    check_eq("t6_cnt", 64'(word_cnt), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
